pwm_ref_ctrl: RTL
=================

PWM_REF_CTRL -- requirements
Module: pwm_ref_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles pwm_ref holds 0 after reset release.
REQ-002 Parameter STEP_CYCLES, default 8: cycles between successive one-LSB changes of pwm_ref (STEP_CYCLES >= 1).
REQ-003 Parameter DEFAULT_REF, default 5'b00110: power-up target level of pwm_ref.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_central  input  1  asynchronous, active-high reset.
REQ-006 req_a  input  1  requester A level request to change the reference.
REQ-007 ref_a  input  5  requester A requested level, sampled on grant.
REQ-008 req_b  input  1  requester B level request to change the reference.
REQ-009 ref_b  input  5  requester B requested level, sampled on grant.
REQ-010 mute  input  1  level; while high, pwm_ref is driven toward 0.
REQ-011 pwm_ref  output  5  registered PWM reference level to the audio PWM datapath.
REQ-012 gnt_a  output  1  one-cycle grant pulse to A.
REQ-013 gnt_b  output  1  one-cycle grant pulse to B.
REQ-014 ready  output  1  high only in state RUN.
REQ-015 busy  output  1  inverse of ready.

Function
REQ-016 States: SETTLE, RAMP, RUN, SLEW, MUTE; all outputs registered.
REQ-017 SETTLE: pwm_ref=0 for exactly SETTLE_CYCLES cycles after reset release, then RAMP (mute low) or MUTE (mute high).
REQ-018 RAMP: target = saved_target = DEFAULT_REF; pwm_ref steps +1 LSB each time the step counter reaches STEP_CYCLES-1, counter then clears.
REQ-019 RAMP/SLEW exit: when pwm_ref equals target, next state RUN; no overshoot, step always one LSB toward target.
REQ-020 RUN: if mute low and req_a or req_b high, grant exactly one requester, pulse its gnt for one cycle, latch target and saved_target from its ref.
REQ-021 Arbitration round-robin: both requesting -> requester not granted last wins; after reset A has priority.
REQ-022 Granted ref equal to current pwm_ref: gnt still pulses, state remains RUN; otherwise next state SLEW, step counter cleared.
REQ-023 Requests outside RUN are ignored (no grant); a held request is served on return to RUN.
REQ-024 Mute high in RAMP, RUN or SLEW: next state MUTE, target 0, saved_target retained, step counter cleared; mute beats a same-cycle request (no grant).
REQ-025 MUTE: pwm_ref steps -1 LSB per STEP_CYCLES down to 0, then holds 0.
REQ-026 Mute low in MUTE: next state SLEW with target=saved_target, step counter cleared.
REQ-027 Mute during SETTLE has no effect until SETTLE ends (REQ-017).
REQ-028 pwm_ref never wraps: never exceeds max(target, current) or goes below 0.
REQ-029 gnt_a and gnt_b never high in the same cycle.

Reset
REQ-030 reset_central high forces immediately, independent of clk: state SETTLE, pwm_ref=0, gnt_a=gnt_b=0, ready=0, busy=1, counters 0, saved_target=DEFAULT_REF, round-robin pointer favouring A.
REQ-031 Reset asserted mid-SLEW or mid-MUTE discards target; full SETTLE+RAMP sequence repeats after release.

Verification (SETTLE_CYCLES=4, STEP_CYCLES=2, DEFAULT_REF=6)
REQ-032 Release reset, no requests -> pwm_ref 0 for 4 cycles, then 1,2,..,6 every 2 cycles; ready rises the cycle after pwm_ref=6.
REQ-033 In RUN, req_a=1 ref_a=10 and req_b=1 ref_b=3 held -> gnt_a pulse, pwm_ref 6->10; back in RUN gnt_b pulse, pwm_ref 10->3.
REQ-034 In RUN at pwm_ref=6, req_b=1 ref_b=6 -> gnt_b one-cycle pulse, ready stays 1, pwm_ref stays 6.
REQ-035 During SLEW 6->10 at pwm_ref=8, mute=1 -> pwm_ref 8,7,..,0 one LSB per 2 cycles; mute=0 -> ramps 0->10, then ready=1.
REQ-036 Same cycle in RUN mute=1 and req_a=1 -> no gnt_a, state MUTE.
REQ-037 Assert reset_central asynchronously (between edges) with pwm_ref=5 -> pwm_ref=0, busy=1 before next clk edge; release -> REQ-032 sequence.

Source files
------------

// File: rtl/pwm_ref_ctrl.sv
// pwm_ref_ctrl
// Generates the 5-bit PWM reference level for the audio PWM datapath.
// After reset the reference is held at 0 for a settle period. It then ramps
// one LSB at a time to a default level. From RUN, two requesters can ask
// for a new level. Mute walks the level down to 0 and later restores the
// last granted level.
//
// Ports
//   clk           sole clock, rising edge
//   reset_central asynchronous active-high reset
//   req_a, ref_a  requester A level request and requested level
//   req_b, ref_b  requester B level request and requested level
//   mute          while high, pwm_ref is driven toward 0
//   pwm_ref       registered reference level
//   gnt_a, gnt_b  one-cycle grant pulses
//   ready         high only in RUN
//   busy          inverse of ready
module pwm_ref_ctrl #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         STEP_CYCLES   = 8,
    parameter logic [4:0] DEFAULT_REF   = 5'b00110
) (
    input  logic       clk,
    input  logic       reset_central,
    input  logic       req_a,
    input  logic [4:0] ref_a,
    input  logic       req_b,
    input  logic [4:0] ref_b,
    input  logic       mute,
    output logic [4:0] pwm_ref,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        SETTLE,
        RAMP,
        RUN,
        SLEW,
        MUTE
    } state_t;

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [4:0]        target;
    logic [4:0]        saved_target;
    logic [STEP_W-1:0] step_cnt;
    logic [SET_W-1:0]  settle_cnt;
    // When set, B wins a tie; cleared after reset so A is favoured first.
    logic              prio_b;

    logic       grant_a;
    logic [4:0] sel_ref;

    // Round-robin pick, only meaningful when at least one request is high.
    assign grant_a = req_a && (!req_b || !prio_b);
    assign sel_ref = grant_a ? ref_a : ref_b;

    // One LSB toward the target; never overshoots and never wraps.
    function automatic logic [4:0] step_toward(input logic [4:0] cur,
                                               input logic [4:0] tgt);
        if (cur < tgt) begin
            return cur + 5'd1;
        end else if (cur > tgt) begin
            return cur - 5'd1;
        end else begin
            return cur;
        end
    endfunction

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            state        <= SETTLE;
            pwm_ref      <= '0;
            target       <= DEFAULT_REF;
            saved_target <= DEFAULT_REF;
            step_cnt     <= '0;
            settle_cnt   <= '0;
            prio_b       <= 1'b0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            ready        <= 1'b0;
            busy         <= 1'b1;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            case (state)
                SETTLE: begin
                    // Mute is only looked at once the settle period is over.
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        step_cnt   <= '0;
                        if (mute) begin
                            state  <= MUTE;
                            target <= '0;
                        end else begin
                            state        <= RAMP;
                            target       <= DEFAULT_REF;
                            saved_target <= DEFAULT_REF;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                RAMP, SLEW: begin
                    if (mute) begin
                        state    <= MUTE;
                        target   <= '0;
                        step_cnt <= '0;
                    end else if (pwm_ref == target) begin
                        state <= RUN;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else if (step_cnt == STEP_LAST) begin
                        pwm_ref  <= step_toward(pwm_ref, target);
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end

                RUN: begin
                    // Mute has priority over a request in the same cycle.
                    if (mute) begin
                        state    <= MUTE;
                        target   <= '0;
                        step_cnt <= '0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end else if (req_a || req_b) begin
                        gnt_a        <= grant_a;
                        gnt_b        <= !grant_a;
                        prio_b       <= grant_a;
                        target       <= sel_ref;
                        saved_target <= sel_ref;
                        // A grant for the level already present stays in RUN.
                        if (sel_ref != pwm_ref) begin
                            state    <= SLEW;
                            step_cnt <= '0;
                            ready    <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                MUTE: begin
                    if (!mute) begin
                        state    <= SLEW;
                        target   <= saved_target;
                        step_cnt <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        pwm_ref  <= step_toward(pwm_ref, target);
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end

                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

endmodule
